// File: rtl/identity_response_checker.sv
// identity_response_checker
//
// Compares the response of an RTL design (y_gold) against the response of
// its synthesized netlist (y_dut) on every accepted sample. It counts
// samples and mismatches, remembers the index of the first mismatch and
// compacts each stream into a MISR signature. A registered pass/fail
// verdict is produced when the stimulus run ends.
//
// Ports
//   clk              : clock, all state changes on the rising edge
//   rst              : asynchronous active-high reset
//   valid            : y_gold / y_dut carry a sample this cycle
//   y_gold, y_dut    : WIDTH-bit responses being compared
//   done             : single-cycle end-of-stimulus pulse
//   sample_count     : accepted samples (saturating)
//   mismatch_count   : samples with y_gold != y_dut (saturating)
//   first_fail_valid : at least one mismatch seen
//   first_fail_index : 0-based index of the first mismatching sample
//   sig_gold/sig_dut : MISR signatures of the two streams
//   result_valid     : verdict is final
//   pass             : verdict, qualified by result_valid
module identity_response_checker #(
    parameter int              WIDTH = 567,
    parameter int              SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF,
    parameter int              CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [WIDTH-1:0]  y_gold,
    input  logic [WIDTH-1:0]  y_dut,
    input  logic              done,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic              first_fail_valid,
    output logic [CNT_W-1:0]  first_fail_index,
    output logic [SIG_W-1:0]  sig_gold,
    output logic [SIG_W-1:0]  sig_dut,
    output logic              result_valid,
    output logic              pass
);

    localparam int NCHUNK = (WIDTH + SIG_W - 1) / SIG_W;
    localparam int PAD_W  = NCHUNK * SIG_W;

    typedef enum logic {RUN, DONE} state_t;

    state_t state, state_nxt;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Zero-pad to a whole number of SIG_W chunks and XOR the chunks together.
    function automatic logic [SIG_W-1:0] fold(input logic [WIDTH-1:0] y);
        logic [PAD_W-1:0] pad;
        logic [SIG_W-1:0] acc;
        pad = '0;
        pad[WIDTH-1:0] = y;
        acc = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            acc = acc ^ pad[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic [SIG_W-1:0] f);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ f;
    endfunction

    // Stage p0: combinational compare and fold in front of the registers
    logic             vld_p0;
    logic             miss_p0;
    logic [SIG_W-1:0] fold_gold_p0;
    logic [SIG_W-1:0] fold_dut_p0;

    assign vld_p0       = (state == RUN) && valid;
    assign miss_p0      = (y_gold != y_dut);
    assign fold_gold_p0 = fold(y_gold);
    assign fold_dut_p0  = fold(y_dut);

    logic [CNT_W-1:0] samp_nxt, mism_nxt, ffi_nxt;
    logic             ffv_nxt, rv_nxt, pass_nxt;
    logic [SIG_W-1:0] sg_nxt, sd_nxt;

    always_comb begin
        state_nxt = state;
        samp_nxt  = sample_count;
        mism_nxt  = mismatch_count;
        ffv_nxt   = first_fail_valid;
        ffi_nxt   = first_fail_index;
        sg_nxt    = sig_gold;
        sd_nxt    = sig_dut;
        rv_nxt    = result_valid;
        pass_nxt  = pass;

        case (state)
            RUN: begin
                if (vld_p0) begin
                    samp_nxt = sat_inc(sample_count);
                    if (miss_p0) begin
                        mism_nxt = sat_inc(mismatch_count);
                        if (!first_fail_valid) begin
                            ffv_nxt = 1'b1;
                            ffi_nxt = sample_count;
                        end
                    end
                    sg_nxt = misr_next(sig_gold, fold_gold_p0);
                    sd_nxt = misr_next(sig_dut,  fold_dut_p0);
                end
                // The verdict folds in a sample accepted on the same edge.
                if (done) begin
                    state_nxt = DONE;
                    rv_nxt    = 1'b1;
                    pass_nxt  = (mism_nxt == '0) && (sg_nxt == sd_nxt);
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Stage p1: result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RUN;
            sample_count     <= '0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
            sig_gold         <= SEED;
            sig_dut          <= SEED;
            result_valid     <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state            <= state_nxt;
            sample_count     <= samp_nxt;
            mismatch_count   <= mism_nxt;
            first_fail_valid <= ffv_nxt;
            first_fail_index <= ffi_nxt;
            sig_gold         <= sg_nxt;
            sig_dut          <= sd_nxt;
            result_valid     <= rv_nxt;
            pass             <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_identity_response_checker.sv
module tb_identity_response_checker;

    localparam int W    = 567;
    localparam int CMAX = 65535;
    localparam logic [31:0] BPOLY = 32'h04C11DB7;
    localparam logic [31:0] BSEED = 32'hFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- full-size instance ----------------
    logic          rst, valid, done;
    logic [W-1:0]  yg, yd;
    logic [15:0]   samp, mism, ffi;
    logic          ffv, rv, pass;
    logic [31:0]   sg, sd;

    identity_response_checker dut (
        .clk(clk), .rst(rst), .valid(valid), .y_gold(yg), .y_dut(yd), .done(done),
        .sample_count(samp), .mismatch_count(mism), .first_fail_valid(ffv),
        .first_fail_index(ffi), .sig_gold(sg), .sig_dut(sd),
        .result_valid(rv), .pass(pass)
    );

    // ---------------- small instance: 8-bit MISR, 4-bit counters ----------------
    logic        rst_s, valid_s, done_s;
    logic [7:0]  g_s, d_s;
    logic [3:0]  s_samp, s_mism, s_ffi;
    logic        s_ffv, s_rv, s_pass;
    logic [7:0]  s_sg, s_sd;

    identity_response_checker #(
        .WIDTH(8), .SIG_W(8), .POLY(8'h07), .SEED(8'h00), .CNT_W(4)
    ) dut_s (
        .clk(clk), .rst(rst_s), .valid(valid_s), .y_gold(g_s), .y_dut(d_s), .done(done_s),
        .sample_count(s_samp), .mismatch_count(s_mism), .first_fail_valid(s_ffv),
        .first_fail_index(s_ffi), .sig_gold(s_sg), .sig_dut(s_sd),
        .result_valid(s_rv), .pass(s_pass)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model for the full-size instance ----------------
    int          m_samp, m_mism, m_ffi;
    bit          m_ffv, m_rv, m_pass, m_fin;
    logic [31:0] m_sg, m_sd;

    // Bit i of the bus lands on signature bit i mod 32.
    function automatic logic [31:0] ref_fold(input logic [W-1:0] y);
        logic [31:0] r = '0;
        for (int i = 0; i < W; i++) r[i % 32] = r[i % 32] ^ y[i];
        return r;
    endfunction

    function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] fb = s[31] ? BPOLY : 32'h0;
        return (s << 1) ^ fb ^ f;
    endfunction

    task automatic model_reset();
        m_samp = 0; m_mism = 0; m_ffi = 0; m_ffv = 0;
        m_rv = 0; m_pass = 0; m_fin = 0;
        m_sg = BSEED; m_sd = BSEED;
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] g, input logic [W-1:0] d, input bit dn);
        if (m_fin) return;
        if (v) begin
            if (g !== d) begin
                if (!m_ffv) begin m_ffv = 1; m_ffi = m_samp; end
                if (m_mism < CMAX) m_mism++;
            end
            if (m_samp < CMAX) m_samp++;
            m_sg = ref_misr(m_sg, ref_fold(g));
            m_sd = ref_misr(m_sd, ref_fold(d));
        end
        if (dn) begin
            m_fin = 1; m_rv = 1;
            m_pass = (m_mism == 0) && (m_sg == m_sd);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sample_count"},     64'(samp), 64'(m_samp));
        chk({tag, ".mismatch_count"},   64'(mism), 64'(m_mism));
        chk({tag, ".first_fail_valid"}, 64'(ffv),  64'(m_ffv));
        chk({tag, ".first_fail_index"}, 64'(ffi),  64'(m_ffi));
        chk({tag, ".sig_gold"},         64'(sg),   64'(m_sg));
        chk({tag, ".sig_dut"},          64'(sd),   64'(m_sd));
        chk({tag, ".result_valid"},     64'(rv),   64'(m_rv));
        chk({tag, ".pass"},             64'(pass), 64'(m_pass));
    endtask

    // Drive one cycle, let the edge happen, then check just after it.
    task automatic apply(input string tag, input bit v, input logic [W-1:0] g,
                         input logic [W-1:0] d, input bit dn);
        valid = v; yg = g; yd = d; done = dn;
        @(posedge clk);
        model_step(v, g, d, dn);
        #1;
        valid = 0; done = 0;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_big(input string tag);
        rst = 1;
        model_reset();
        #1;
        check_all(tag);
        rst = 0;
    endtask

    function automatic logic [W-1:0] rand_bus();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom);
        return r;
    endfunction

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] g;
        logic [7:0] d;
        bit         dn;
        logic [7:0] e_sig;
        int         e_samp;
        int         e_mism;
        bit         e_rv;
        bit         e_pass;
    } vec_t;

    vec_t        tbl[8];
    logic [W-1:0] stream[21];
    logic [W-1:0] g, d;

    initial begin
        rst = 1; valid = 0; done = 0; yg = '0; yd = '0;
        rst_s = 1; valid_s = 0; done_s = 0; g_s = '0; d_s = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        rst = 0; rst_s = 0;

        // ---- MISR arithmetic table on the 8-bit instance ----
        tbl[0] = '{0, 1, 8'h01, 8'h01, 0, 8'h01, 1, 0, 0, 0};
        tbl[1] = '{0, 1, 8'h00, 8'h00, 0, 8'h02, 2, 0, 0, 0};
        tbl[2] = '{1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 8'h80, 8'h80, 0, 8'h80, 1, 0, 0, 0};
        tbl[4] = '{0, 1, 8'h00, 8'h00, 0, 8'h07, 2, 0, 0, 0};
        tbl[5] = '{0, 0, 8'h55, 8'hAA, 0, 8'h07, 2, 0, 0, 0};
        tbl[6] = '{0, 1, 8'h00, 8'h01, 0, 8'h0E, 3, 1, 0, 0};
        tbl[7] = '{0, 0, 8'h00, 8'h00, 1, 8'h0E, 3, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst) begin
                rst_s = 1; #1;
                rst_s = 0;
            end else begin
                valid_s = tbl[i].v; g_s = tbl[i].g; d_s = tbl[i].d; done_s = tbl[i].dn;
                @(posedge clk); #1;
                valid_s = 0; done_s = 0;
            end
            chk($sformatf("tbl%0d.sig_gold", i),       64'(s_sg),   64'(tbl[i].e_sig));
            chk($sformatf("tbl%0d.sample_count", i),   64'(s_samp), 64'(tbl[i].e_samp));
            chk($sformatf("tbl%0d.mismatch_count", i), 64'(s_mism), 64'(tbl[i].e_mism));
            chk($sformatf("tbl%0d.result_valid", i),   64'(s_rv),   64'(tbl[i].e_rv));
            chk($sformatf("tbl%0d.pass", i),           64'(s_pass), 64'(tbl[i].e_pass));
        end

        // ---- saturation on 4-bit counters ----
        rst_s = 1; #1; rst_s = 0;
        for (int i = 0; i < 20; i++) begin
            valid_s = 1; g_s = 8'(i); d_s = ~8'(i);
            @(posedge clk); #1;
        end
        valid_s = 0;
        chk("sat.mismatch_count",   64'(s_mism), 64'd15);
        chk("sat.sample_count",     64'(s_samp), 64'd15);
        chk("sat.first_fail_index", 64'(s_ffi),  64'd0);
        chk("sat.first_fail_valid", 64'(s_ffv),  64'd1);
        done_s = 1; @(posedge clk); #1; done_s = 0;
        chk("sat.result_valid", 64'(s_rv),   64'd1);
        chk("sat.pass",         64'(s_pass), 64'd0);

        // ---- identical streams ----
        for (int i = 0; i < 21; i++) stream[i] = rand_bus();
        reset_big("t1.rst");
        for (int i = 0; i < 21; i++) apply("t1", 1, stream[i], stream[i], 0);
        apply("t1.done", 0, '0, '0, 1);
        chk("t1.sample_count",     64'(samp), 64'd21);
        chk("t1.mismatch_count",   64'(mism), 64'd0);
        chk("t1.first_fail_valid", 64'(ffv),  64'd0);
        chk("t1.sig_equal",        64'(sg == sd), 64'd1);
        chk("t1.pass",             64'(pass), 64'd1);

        // ---- single-bit fault on bit 566, sample 3 ----
        reset_big("t2.rst");
        for (int i = 0; i < 21; i++) begin
            d = stream[i];
            if (i == 3) d[566] = ~d[566];
            apply("t2", 1, stream[i], d, 0);
        end
        apply("t2.done", 0, '0, '0, 1);
        chk("t2.first_fail_index", 64'(ffi),  64'd3);
        chk("t2.mismatch_count",   64'(mism), 64'd1);
        chk("t2.pass",             64'(pass), 64'd0);
        chk("t2.sig_differ",       64'(sg != sd), 64'd1);

        // ---- zero-sample run ----
        reset_big("t0.rst");
        apply("t0.done", 0, '0, '0, 1);
        chk("t0.pass",         64'(pass), 64'd1);
        chk("t0.sample_count", 64'(samp), 64'd0);

        // ---- valid and done together, then late pulses ----
        reset_big("t5.rst");
        g = rand_bus(); d = g; d[0] = ~d[0];
        apply("t5.both", 1, g, d, 1);
        chk("t5.mismatch_count", 64'(mism), 64'd1);
        chk("t5.pass",           64'(pass), 64'd0);
        chk("t5.result_valid",   64'(rv),   64'd1);
        for (int i = 0; i < 4; i++) apply("t5.late", 1, rand_bus(), rand_bus(), i[0]);
        chk("t5.late.sample_count", 64'(samp), 64'd1);

        // ---- reset mid-run ----
        reset_big("t6.rst");
        for (int i = 0; i < 5; i++) begin
            g = rand_bus(); d = ~g;
            apply("t6.miss", 1, g, d, 0);
        end
        rst = 1; #1;
        model_reset();
        chk("t6.async.sample_count",   64'(samp), 64'd0);
        chk("t6.async.mismatch_count", 64'(mism), 64'd0);
        chk("t6.async.ffv",            64'(ffv),  64'd0);
        chk("t6.async.sig_gold",       64'(sg),   64'(BSEED));
        check_all("t6.async");
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            g = rand_bus();
            apply("t6.clean", 1, g, g, 0);
        end
        apply("t6.done", 0, '0, '0, 1);
        chk("t6.pass",         64'(pass), 64'd1);
        chk("t6.sample_count", 64'(samp), 64'd3);

        // ---- randomized runs against the model ----
        for (int run = 0; run < 6; run++) begin
            int n;
            reset_big("rnd.rst");
            n = $urandom_range(40, 5);
            for (int k = 0; k < n; k++) begin
                bit v;
                v = ($urandom % 4) != 0;
                g = rand_bus(); d = g;
                if (($urandom % 8) == 0) begin
                    int b;
                    b = $urandom_range(W - 1, 0);
                    d[b] = ~d[b];
                end
                apply("rnd", v, g, d, k == n - 1);
            end
            for (int k = 0; k < 3; k++) apply("rnd.post", 1'($urandom), rand_bus(), rand_bus(), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
